// File: rtl/board_loader.sv
// board_loader: Sudoku board store, loaded cell-by-cell from a map snapshot.
// Each cell is 5 bits: bit4 = fixed flag, bits3:0 = value (0 = empty).
// Ports:
//   clk, reset (async, active-low)
//   selected_map  81 cells x 5 bits; cell i = row*9+col at [i*5 +: 5]
//   load_req      pulse: snapshot the map and copy it in over 81 cycles
//   wr_en/wr_row/wr_col/wr_value   player write; wr_ack/wr_nack answer it one cycle later
//   rd_row/rd_col -> rd_cell       combinational read; 0 when off-board
//   busy (LOAD), ready (READY), filled_count (nonzero cells), board_full
// Optional macro REJECT_COUNT_EN adds reject_count: saturating count of wr_nack
// pulses, cleared by reset and by an accepted load.
module board_loader (
    input  logic         clk,
    input  logic         reset,
    input  logic [404:0] selected_map,
    input  logic         load_req,
    input  logic         wr_en,
    input  logic [3:0]   wr_row,
    input  logic [3:0]   wr_col,
    input  logic [3:0]   wr_value,
    input  logic [3:0]   rd_row,
    input  logic [3:0]   rd_col,
    output logic [4:0]   rd_cell,
    output logic         busy,
    output logic         ready,
    output logic         wr_ack,
    output logic         wr_nack,
    output logic [6:0]   filled_count,
    output logic         board_full
`ifdef REJECT_COUNT_EN
    ,
    output logic [7:0]   reject_count
`endif
);
    typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

    state_t       r_state;
    logic [404:0] r_shadow, r_board;
    logic [6:0]   r_idx, r_filled;
    logic         r_busy, r_ready, r_ack, r_nack;

    logic [7:0]   w_widx, w_ridx;
    logic [8:0]   w_wbase, w_rbase, w_lbase;
    logic         w_wr_in, w_rd_in, w_load, w_wr_ok, w_nack;
    logic [4:0]   w_cur, w_ld_cell;

    assign w_widx    = {4'd0, wr_row} * 8'd9 + {4'd0, wr_col};
    assign w_ridx    = {4'd0, rd_row} * 8'd9 + {4'd0, rd_col};
    assign w_wbase   = {1'b0, w_widx} * 9'd5;
    assign w_rbase   = {1'b0, w_ridx} * 9'd5;
    assign w_lbase   = {2'b0, r_idx} * 9'd5;
    assign w_wr_in   = wr_row <= 4'd8 && wr_col <= 4'd8;
    assign w_rd_in   = rd_row <= 4'd8 && rd_col <= 4'd8;
    assign w_cur     = w_wr_in ? r_board[w_wbase +: 5] : 5'd0;
    assign w_ld_cell = r_shadow[w_lbase +: 5];
    // A load request outside LOAD always wins over a simultaneous write.
    assign w_load    = load_req && r_state != LOAD;
    assign w_wr_ok   = wr_en && r_state == READY && !load_req && w_wr_in &&
                       wr_value <= 4'd9 && !w_cur[4];
    assign w_nack    = wr_en && !w_wr_ok;

    assign rd_cell      = w_rd_in ? r_board[w_rbase +: 5] : 5'd0;
    assign busy         = r_busy;
    assign ready        = r_ready;
    assign wr_ack       = r_ack;
    assign wr_nack      = r_nack;
    assign filled_count = r_filled;
    assign board_full   = r_filled == 7'd81;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_shadow <= '0;
            r_board  <= '0;
            r_idx    <= '0;
            r_filled <= '0;
            r_busy   <= 1'b0;
            r_ready  <= 1'b0;
            r_ack    <= 1'b0;
            r_nack   <= 1'b0;
        end else begin
            r_ack  <= w_wr_ok;
            r_nack <= w_nack;
            if (w_load) begin
                // Board is cleared so filled_count tracks only the cells loaded so far.
                r_shadow <= selected_map;
                r_board  <= '0;
                r_filled <= '0;
                r_idx    <= '0;
                r_state  <= LOAD;
                r_busy   <= 1'b1;
                r_ready  <= 1'b0;
            end else if (r_state == LOAD) begin
                r_board[w_lbase +: 5] <= w_ld_cell;
                r_filled <= r_filled + {6'd0, |w_ld_cell[3:0]};
                r_idx    <= r_idx + 7'd1;
                if (r_idx == 7'd80) begin
                    r_state <= READY;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            end else if (w_wr_ok) begin
                r_board[w_wbase +: 5] <= {1'b0, wr_value};
                r_filled <= (~|w_cur[3:0] && |wr_value) ? r_filled + 7'd1 :
                            (|w_cur[3:0] && ~|wr_value) ? r_filled - 7'd1 : r_filled;
            end
        end
    end

`ifdef REJECT_COUNT_EN
    logic [7:0] r_rej;

    assign reject_count = r_rej;

    // A nack coinciding with an accepted load is counted after the clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_rej <= '0;
        else if (w_load)
            r_rej <= {7'd0, w_nack};
        else if (w_nack && r_rej != 8'd255)
            r_rej <= r_rej + 8'd1;
    end
`endif
endmodule

// File: tb/tb_board_loader.sv
// tb_board_loader: directed + randomized check of board_loader against a cell-array model.
module tb_board_loader;
    logic         clk = 0, reset = 0, load_req = 0, wr_en = 0;
    logic [404:0] selected_map = '0;
    logic [3:0]   wr_row = 0, wr_col = 0, wr_value = 0, rd_row = 0, rd_col = 0;
    logic [4:0]   rd_cell;
    logic         busy, ready, wr_ack, wr_nack, board_full;
    logic [6:0]   filled_count;
`ifdef REJECT_COUNT_EN
    logic [7:0]   reject_count;
`endif
    int checks = 0, errors = 0;

    board_loader dut (
        .clk(clk), .reset(reset), .selected_map(selected_map), .load_req(load_req),
        .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_value(wr_value),
        .rd_row(rd_row), .rd_col(rd_col), .rd_cell(rd_cell), .busy(busy), .ready(ready),
        .wr_ack(wr_ack), .wr_nack(wr_nack), .filled_count(filled_count), .board_full(board_full)
`ifdef REJECT_COUNT_EN
        , .reject_count(reject_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0 idle, 1 loading, 2 ready; board as an array of cells.
    logic [4:0] m_board[81];
    logic [4:0] m_shadow[81];
    int         m_mode = 0, m_pos = 0, m_rej = 0;
    logic       m_ack = 0, m_nack = 0;

    function automatic int m_filled();
        int n = 0;
        if (m_mode == 1)
            for (int i = 0; i < m_pos; i++) n += (m_shadow[i][3:0] != 0) ? 1 : 0;
        else
            for (int i = 0; i < 81; i++) n += (m_board[i][3:0] != 0) ? 1 : 0;
        return n;
    endfunction

    task automatic m_step();
        int t;
        bit ok;
        t  = wr_row * 9 + wr_col;
        ok = wr_en && m_mode == 2 && !load_req && wr_row <= 8 && wr_col <= 8 && wr_value <= 9;
        if (ok && m_board[t][4]) ok = 0;
        m_ack  = ok;
        m_nack = wr_en && !ok;
        if (load_req && m_mode != 1) begin
            for (int i = 0; i < 81; i++) m_shadow[i] = selected_map[i*5 +: 5];
            m_pos  = 0;
            m_mode = 1;
            m_rej  = m_nack ? 1 : 0;
        end else begin
            if (m_nack && m_rej < 255) m_rej++;
            if (m_mode == 1) begin
                m_board[m_pos] = m_shadow[m_pos];
                m_pos++;
                if (m_pos == 81) m_mode = 2;
            end else if (ok) m_board[t] = {1'b0, wr_value};
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 81; i++) m_board[i] = '0;
            m_mode = 0; m_pos = 0; m_rej = 0; m_ack = 0; m_nack = 0;
        end else m_step();
    end

    always @(negedge clk) begin
        chk("busy", busy, m_mode == 1);
        chk("ready", ready, m_mode == 2);
        chk("wr_ack", wr_ack, m_ack);
        chk("wr_nack", wr_nack, m_nack);
        chk("filled_count", filled_count, m_filled());
        chk("board_full", board_full, m_filled() == 81);
`ifdef REJECT_COUNT_EN
        chk("reject_count", reject_count, m_rej);
`endif
        if (m_mode != 1)
            chk("rd_cell", rd_cell, (rd_row <= 8 && rd_col <= 8) ? m_board[rd_row*9 + rd_col] : 5'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(string n, int r, int c, logic [4:0] e);
        rd_row = 4'(r);
        rd_col = 4'(c);
        #1;
        chk(n, rd_cell, e);
    endtask

    task automatic wr(int r, int c, int v);
        wr_en = 1; wr_row = 4'(r); wr_col = 4'(c); wr_value = 4'(v);
        tick();
        wr_en = 0;
    endtask

    task automatic do_load(logic [404:0] m);
        selected_map = m;
        load_req = 1;
        tick();
        load_req = 0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 300) begin
            tick();
            n++;
        end
        chk("ready_timeout", ready, 1);
    endtask

    task automatic count_busy(string name);
        int n = 0;
        while (busy && n < 200) begin
            n++;
            tick();
        end
        chk(name, n, 81);
        chk({name, "_ready"}, ready, 1);
    endtask

    function automatic logic [404:0] rand_map();
        logic [404:0] m = '0;
        for (int i = 0; i < 81; i++)
            m[i*5 +: 5] = {($urandom_range(0, 2) == 0), 4'($urandom_range(0, 9))};
        return m;
    endfunction

    initial begin
        logic [404:0] m1, m2;
        m1 = '0;
        for (int i = 0; i < 30; i++) m1[i*5 +: 5] = {1'b1, 4'(i % 9 + 1)};
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_ready", ready, 0);
        chk("rst_filled", filled_count, 0);
        chk("rst_full", board_full, 0);
        chk("rst_ack", wr_ack, 0);
        chk("rst_nack", wr_nack, 0);
        rd_chk("rst_rd", 3, 3, 5'd0);
        reset = 1;
        tick();

        do_load(m1);
        count_busy("load_busy81");
        chk("load_fill30", filled_count, 30);
        rd_chk("rd_0_0", 0, 0, 5'h11);
        rd_chk("rd_0_1", 0, 1, 5'h12);
        rd_chk("rd_8_8", 8, 8, 5'h00);
        rd_chk("rd_off", 9, 2, 5'h00);

        wr(5, 5, 5);
        chk("w5_ack", wr_ack, 1);
        chk("w5_nack", wr_nack, 0);
        rd_chk("w5_rd", 5, 5, 5'b00101);
        chk("w5_fill", filled_count, 31);
        wr(5, 5, 0);
        chk("w0_ack", wr_ack, 1);
        chk("w0_fill", filled_count, 30);
        rd_chk("w0_rd", 5, 5, 5'd0);

        wr(0, 0, 3);
        chk("nack_fixed", wr_nack, 1);
        wr(9, 0, 3);
        chk("nack_row9", wr_nack, 1);
        wr(6, 6, 10);
        chk("nack_val10", wr_nack, 1);
        chk("nack_noack", wr_ack, 0);
        rd_chk("nack_rd00", 0, 0, 5'h11);
        rd_chk("nack_rd66", 6, 6, 5'h00);
        chk("nack_fill", filled_count, 30);
`ifdef REJECT_COUNT_EN
        chk("reject3", reject_count, 3);
`endif

        m2 = rand_map();
        selected_map = m2;
        load_req = 1; wr_en = 1; wr_row = 4; wr_col = 4; wr_value = 7;
        tick();
        load_req = 0; wr_en = 0;
        chk("coll_nack", wr_nack, 1);
        chk("coll_busy", busy, 1);
        wait_ready();
        rd_chk("coll_rd44", 4, 4, m2[200 +: 5]);

        do_load(m1);
        repeat (40) tick();
        chk("mid_busy", busy, 1);
        reset = 0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_fill", filled_count, 0);
        tick();
        for (int i = 0; i < 81; i++) rd_chk("mid_rst_rd", i / 9, i % 9, 5'd0);
        reset = 1;
        tick();
        chk("idle_ready", ready, 0);
        do_load(m1);
        count_busy("reload_busy81");
        chk("reload_fill", filled_count, 30);

        do_load('0);
        wait_ready();
        chk("empty_fill", filled_count, 0);
        for (int i = 0; i < 81; i++) wr(i / 9, i % 9, i % 9 + 1);
        chk("full_fill", filled_count, 81);
        chk("full_flag", board_full, 1);
        wr(8, 8, 0);
        chk("unfull_fill", filled_count, 80);
        chk("unfull_flag", board_full, 0);
        wr(0, 0, 4);
        chk("nz_nz_ack", wr_ack, 1);
        chk("nz_nz_fill", filled_count, 80);

        repeat (4000) begin
            wr_en    = 1'($urandom_range(0, 1));
            wr_row   = 4'($urandom_range(0, 9));
            wr_col   = 4'($urandom_range(0, 9));
            wr_value = 4'($urandom_range(0, 10));
            rd_row   = 4'($urandom_range(0, 9));
            rd_col   = 4'($urandom_range(0, 9));
            load_req = ($urandom_range(0, 199) == 0);
            if (load_req) selected_map = rand_map();
            reset    = ($urandom_range(0, 1999) != 0);
            tick();
        end
        load_req = 0; wr_en = 0; reset = 1;
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
